blk_arbiter: RTL and testbench

//  Downstream collector for NCH per-channel processors (prc1chan). Polls channels round-robin via
//  the give/have handshake and copies one whole block (CW + L words) per grant. Merges the blocks

---
 rtl/blk_arbiter.sv | 200 ++++++++++++++++++++
 tb/tb_blk_arbiter.sv | 363 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/blk_arbiter.sv
// Round-robin block collector: polls NCH channel processors with give/have, copies one
// whole block (CW + L words) per grant and merges them into one 16-bit valid/ready stream.
module blk_arbiter #(
    parameter int NCH = 16,
    parameter int CHB = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [NCH-1:0]   chan_en,
    output logic [NCH-1:0]   give,
    input  logic [NCH-1:0]   have,
    input  logic [16*NCH-1:0] din,
    output logic [15:0]      odata,
    output logic             ovalid,
    input  logic             oready,
    output logic             osop,
    output logic             oeop,
    output logic             cw_err,
    output logic             blk_err,
    output logic [31:0]      nblk
);

    typedef enum logic [1:0] {
        SCAN  = 2'd0,
        BLOCK = 2'd1,
        PAD   = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [CHB-1:0]  ptr_q, ptr_d;
    logic [8:0]      cnt_q, cnt_d;
    logic [15:0]     odata_q, odata_d;
    logic            ovalid_q, ovalid_d;
    logic            osop_q, osop_d;
    logic            oeop_q, oeop_d;
    logic            cw_err_q, cw_err_d;
    logic            blk_err_q, blk_err_d;
    logic [31:0]     nblk_q, nblk_d;

    logic            take;
    logic            give_act;
    logic            cur_en;
    logic            cur_have;
    logic [15:0]     cur_din;
    logic [CHB-1:0]  ptr_nxt;

    function automatic logic [CHB-1:0] next_ptr(input logic [CHB-1:0] p);
        if (p == CHB'(NCH - 1)) begin
            return '0;
        end
        return p + CHB'(1);
    endfunction

    // Select the channel currently addressed by the pointer.
    always_comb begin
        cur_en   = 1'b0;
        cur_have = 1'b0;
        cur_din  = 16'h0000;
        for (int i = 0; i < NCH; i++) begin
            if (ptr_q == CHB'(i)) begin
                cur_en   = chan_en[i];
                cur_have = have[i];
                cur_din  = din[16*i +: 16];
            end
        end
    end

    assign ptr_nxt = next_ptr(ptr_q);
    assign take    = ~ovalid_q | oready;

    // Once a block is open the channel is served to the end, even if its enable drops.
    assign give_act = ~reset & take &
                      (((state_q == SCAN) & cur_en) | (state_q == BLOCK));

    always_comb begin
        give = '0;
        for (int i = 0; i < NCH; i++) begin
            give[i] = give_act && (ptr_q == CHB'(i));
        end
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        odata_d   = odata_q;
        ovalid_d  = ovalid_q;
        osop_d    = osop_q;
        oeop_d    = oeop_q;
        cw_err_d  = 1'b0;
        blk_err_d = 1'b0;
        nblk_d    = nblk_q;

        if (take) begin
            ovalid_d = 1'b0;
        end

        case (state_q)
            SCAN: begin
                if (!cur_en) begin
                    ptr_d = ptr_nxt;
                end else if (take) begin
                    if (!cur_have) begin
                        ptr_d = ptr_nxt;
                    end else if (cur_din[15]) begin
                        odata_d  = cur_din;
                        ovalid_d = 1'b1;
                        osop_d   = 1'b1;
                        oeop_d   = (cur_din[8:0] == 9'd0);
                        cnt_d    = cur_din[8:0];
                        if (cur_din[8:0] == 9'd0) begin
                            nblk_d = nblk_q + 32'd1;
                            ptr_d  = ptr_nxt;
                        end else begin
                            state_d = BLOCK;
                        end
                    end else begin
                        cw_err_d = 1'b1;
                        ptr_d    = ptr_nxt;
                    end
                end
            end

            BLOCK: begin
                if (take) begin
                    if (cur_have) begin
                        odata_d  = cur_din;
                        ovalid_d = 1'b1;
                        osop_d   = 1'b0;
                        oeop_d   = (cnt_q == 9'd1);
                        cnt_d    = cnt_q - 9'd1;
                        if (cnt_q == 9'd1) begin
                            nblk_d  = nblk_q + 32'd1;
                            ptr_d   = ptr_nxt;
                            state_d = SCAN;
                        end
                    end else begin
                        blk_err_d = 1'b1;
                        state_d   = PAD;
                    end
                end
            end

            PAD: begin
                // Fill with zeros so the declared block length still holds downstream.
                if (take) begin
                    odata_d  = 16'h0000;
                    ovalid_d = 1'b1;
                    osop_d   = 1'b0;
                    oeop_d   = (cnt_q == 9'd1);
                    cnt_d    = cnt_q - 9'd1;
                    if (cnt_q == 9'd1) begin
                        nblk_d  = nblk_q + 32'd1;
                        ptr_d   = ptr_nxt;
                        state_d = SCAN;
                    end
                end
            end

            default: begin
                state_d = SCAN;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= SCAN;
            ptr_q     <= '0;
            cnt_q     <= 9'd0;
            odata_q   <= 16'h0000;
            ovalid_q  <= 1'b0;
            osop_q    <= 1'b0;
            oeop_q    <= 1'b0;
            cw_err_q  <= 1'b0;
            blk_err_q <= 1'b0;
            nblk_q    <= 32'd0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            odata_q   <= odata_d;
            ovalid_q  <= ovalid_d;
            osop_q    <= osop_d;
            oeop_q    <= oeop_d;
            cw_err_q  <= cw_err_d;
            blk_err_q <= blk_err_d;
            nblk_q    <= nblk_d;
        end
    end

    assign odata   = odata_q;
    assign ovalid  = ovalid_q;
    assign osop    = osop_q;
    assign oeop    = oeop_q;
    assign cw_err  = cw_err_q;
    assign blk_err = blk_err_q;
    assign nblk    = nblk_q;

endmodule

// File: tb/tb_blk_arbiter.sv
// Bench for blk_arbiter: channel sources are word queues; a transaction-level model walks the
// channels in round-robin passes to predict the merged output stream and error counts.
module tb_blk_arbiter;

    localparam int NCH = 16;
    localparam int CHB = 4;

    typedef struct packed {
        logic [15:0] d;
        logic        sop;
        logic        eop;
    } exp_t;

    logic              clk;
    logic              reset;
    logic [NCH-1:0]    chan_en;
    logic [NCH-1:0]    give;
    logic [NCH-1:0]    have;
    logic [16*NCH-1:0] din;
    logic [15:0]       odata;
    logic              ovalid;
    logic              oready;
    logic              osop;
    logic              oeop;
    logic              cw_err;
    logic              blk_err;
    logic [31:0]       nblk;

    blk_arbiter #(.NCH(NCH), .CHB(CHB)) dut (
        .clk(clk), .reset(reset), .chan_en(chan_en), .give(give), .have(have), .din(din),
        .odata(odata), .ovalid(ovalid), .oready(oready), .osop(osop), .oeop(oeop),
        .cw_err(cw_err), .blk_err(blk_err), .nblk(nblk)
    );

    initial begin
        clk = 1'b0;
        forever #4 clk = ~clk;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog expired");
    end

    int checks = 0;
    int errors = 0;

    logic [15:0] chq [NCH][$];
    logic [15:0] mq  [NCH][$];
    int          ld_cnt [NCH];
    exp_t        expq [$];
    int exp_blocks, exp_cwerr, exp_blkerr;
    int got_cwerr, got_blkerr;
    int omode, oprob;
    bit chk_en;
    bit prev_stall;
    logic [17:0] prev_out;
    int nvalid, vfirst, vlast, cyc;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, req);
        end
    endtask

    function automatic exp_t mk(input logic [15:0] d, input logic s, input logic e);
        exp_t r;
        r.d   = d;
        r.sop = s;
        r.eop = e;
        return r;
    endfunction

    task automatic load(input int ch, input int len, input int nd);
        chq[ch].push_back({1'b1, 6'(ch), 9'(len)});
        for (int k = 0; k < nd; k++) chq[ch].push_back(16'($urandom));
    endtask

    task automatic drive();
        for (int i = 0; i < NCH; i++) begin
            have[i] = (chq[i].size() > 0);
            din[16*i +: 16] = (chq[i].size() > 0) ? chq[i][0] : 16'h0000;
        end
        if (omode == 1)      oready = ~oready;
        else if (omode == 2) oready = ($urandom_range(0, 99) < oprob);
        else                 oready = 1'b1;
    endtask

    // Channels visited in ascending order, pass after pass; each visit of an enabled,
    // non-empty channel consumes one unit: a whole block, or a single bad leading word.
    task automatic build_model();
        logic [15:0] w, d;
        int len;
        bit any, trunc;
        expq.delete();
        exp_blocks = 0; exp_cwerr = 0; exp_blkerr = 0;
        for (int i = 0; i < NCH; i++) begin
            mq[i] = chq[i];
            ld_cnt[i] = chq[i].size();
        end
        do begin
            any = 0;
            for (int ch = 0; ch < NCH; ch++) begin
                if (chan_en[ch] && mq[ch].size() > 0) begin
                    any = 1;
                    w = mq[ch].pop_front();
                    if (w[15]) begin
                        len = int'(w[8:0]);
                        expq.push_back(mk(w, 1'b1, len == 0));
                        exp_blocks++;
                        trunc = 0;
                        for (int k = 1; k <= len; k++) begin
                            if (mq[ch].size() > 0) d = mq[ch].pop_front();
                            else begin
                                d = 16'h0000;
                                if (!trunc) exp_blkerr++;
                                trunc = 1;
                            end
                            expq.push_back(mk(d, 1'b0, k == len));
                        end
                    end else begin
                        exp_cwerr++;
                    end
                end
            end
        end while (any);
    endtask

    task automatic compare();
        exp_t e;
        chk("give_onehot", 32'($onehot0(give)), 32'd1);
        chk("give_disabled", 32'(give & ~chan_en), 32'd0);
        if (prev_stall) begin
            chk("stall_valid", 32'(ovalid), 32'd1);
            chk("stall_hold", 32'({odata, osop, oeop}), 32'(prev_out));
        end
        if (ovalid) begin
            if (vfirst < 0) vfirst = cyc;
            vlast = cyc;
            nvalid++;
        end
        if (ovalid && oready) begin
            if (expq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL extra_word: got 0x%0h, required no further word", odata);
            end else begin
                e = expq.pop_front();
                chk("odata", 32'(odata), 32'(e.d));
                chk("osop", 32'(osop), 32'(e.sop));
                chk("oeop", 32'(oeop), 32'(e.eop));
            end
        end
        if (cw_err)  got_cwerr++;
        if (blk_err) got_blkerr++;
        prev_stall = ovalid && !oready;
        prev_out   = {odata, osop, oeop};
        cyc++;
    endtask

    task automatic cycle();
        logic [NCH-1:0] m;
        logic [15:0] tmp;
        @(negedge clk);
        m = give & have;
        if (chk_en) compare();
        @(posedge clk);
        #1;
        for (int i = 0; i < NCH; i++) begin
            if (m[i] && chq[i].size() > 0) tmp = chq[i].pop_front();
        end
        drive();
    endtask

    task automatic begin_phase(input logic [NCH-1:0] en, input int mode);
        reset = 1'b1;
        chk_en = 0;
        chan_en = en;
        omode = mode;
        oready = 1'b1;
        for (int i = 0; i < NCH; i++) chq[i].delete();
        expq.delete();
        got_cwerr = 0; got_blkerr = 0;
        nvalid = 0; vfirst = -1; vlast = -1; cyc = 0;
        prev_stall = 0;
        drive();
        @(posedge clk);
        #1;
    endtask

    task automatic go();
        build_model();
        drive();
        @(negedge clk);
        chk("rst_give", 32'(give), 32'd0);
        chk("rst_ovalid", 32'(ovalid), 32'd0);
        chk("rst_odata", 32'(odata), 32'd0);
        chk("rst_osop", 32'(osop), 32'd0);
        chk("rst_oeop", 32'(oeop), 32'd0);
        chk("rst_cw_err", 32'(cw_err), 32'd0);
        chk("rst_blk_err", 32'(blk_err), 32'd0);
        chk("rst_nblk", nblk, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk_en = 1;
        drive();
    endtask

    task automatic run_phase(input string nm);
        int n = 0;
        while (expq.size() > 0 && n < 5000) begin
            cycle();
            n++;
        end
        if (expq.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: %0d words still expected, required 0", nm, expq.size());
        end
        repeat (3 * NCH) cycle();
        chk({nm, "_nblk"}, nblk, 32'(exp_blocks));
        chk({nm, "_cw_err"}, 32'(got_cwerr), 32'(exp_cwerr));
        chk({nm, "_blk_err"}, 32'(got_blkerr), 32'(exp_blkerr));
        for (int i = 0; i < NCH; i++) begin
            if (chan_en[i]) chk({nm, "_drained"}, 32'(chq[i].size()), 32'd0);
            else            chk({nm, "_untouched"}, 32'(chq[i].size()), 32'(ld_cnt[i]));
        end
    endtask

    initial begin
        logic [NCH-1:0] en;
        logic [23:0] ord;
        int nb, len, nd, n;

        reset = 1'b1; oready = 1'b1; chan_en = '1; have = '0; din = '0;
        omode = 0; oprob = 100; chk_en = 0;

        // single block on ch3, continuous ready
        begin_phase('1, 0);
        load(3, 5, 5);
        go();
        chk("t1_model_len", 32'(expq.size()), 32'd6);
        chk("t1_model_cw", 32'(expq[0].d), 32'h8605);
        chk("t1_model_eop", 32'(expq[5].eop), 32'd1);
        run_phase("t1");
        chk("t1_nvalid", 32'(nvalid), 32'd6);
        chk("t1_span", 32'(vlast - vfirst + 1), 32'd6);

        // same block with ready toggling
        begin_phase('1, 1);
        load(3, 5, 5);
        go();
        run_phase("t3");

        // round-robin across ch0, ch1, ch5 with two blocks each
        begin_phase('1, 0);
        for (int b = 0; b < 2; b++) begin
            load(0, $urandom_range(1, 4), 0);
            load(1, $urandom_range(1, 4), 0);
            load(5, $urandom_range(1, 4), 0);
        end
        for (int ch = 0; ch < NCH; ch++) begin
            chq[ch].delete();
        end
        for (int b = 0; b < 2; b++) begin
            foreach (chq[0][j]) ;
            len = $urandom_range(1, 4); load(0, len, len);
            len = $urandom_range(1, 4); load(1, len, len);
            len = $urandom_range(1, 4); load(5, len, len);
        end
        go();
        ord = 24'h0;
        foreach (expq[j]) if (expq[j].sop) ord = {ord[19:0], expq[j].d[12:9]};
        chk("t2_model_order", 32'(ord), 32'h015015);
        run_phase("t2");

        // ch2 runs dry after 2 of 5 data words
        begin_phase('1, 0);
        load(2, 5, 2);
        go();
        chk("t4_model_len", 32'(expq.size()), 32'd6);
        chk("t4_model_pad", 32'(expq[3].d), 32'd0);
        chk("t4_model_eop", 32'(expq[5].eop), 32'd1);
        chk("t4_model_blkerr", 32'(exp_blkerr), 32'd1);
        run_phase("t4");

        // bad control word on ch7, disabled ch4 holding data
        en = '1; en[4] = 1'b0;
        begin_phase(en, 0);
        chq[7].push_back(16'h1234);
        load(8, 3, 3);
        load(4, 2, 2);
        go();
        chk("t5_model_cwerr", 32'(exp_cwerr), 32'd1);
        chk("t5_model_first", 32'(expq[0].d[14:9]), 32'd8);
        run_phase("t5");

        // maximum length block and pointer wrap
        begin_phase('1, 0);
        load(0, 0, 0); load(15, 511, 511); load(0, 0, 0); load(15, 1, 1);
        go();
        chk("t7_model_len", 32'(expq.size()), 32'd516);
        run_phase("t7");

        // randomized traffic, enables and backpressure
        for (int p = 0; p < 6; p++) begin
            for (int i = 0; i < NCH; i++) en[i] = ($urandom_range(0, 4) != 0);
            begin_phase(en, 2);
            oprob = $urandom_range(30, 100);
            for (int ch = 0; ch < NCH; ch++) begin
                nb = $urandom_range(0, 3);
                for (int b = 0; b < nb; b++) begin
                    if ($urandom_range(0, 7) == 0) begin
                        chq[ch].push_back({1'b0, 15'($urandom)});
                    end else begin
                        len = $urandom_range(0, 10);
                        nd = len;
                        if (b == nb - 1 && $urandom_range(0, 4) == 0) nd = $urandom_range(0, len);
                        load(ch, len, nd);
                    end
                end
            end
            go();
            run_phase("rnd");
        end

        // reset in the middle of a block
        begin_phase('1, 0);
        load(1, 2, 2);
        load(3, 40, 40);
        go();
        n = 0;
        while (!(nblk == 32'd1 && expq.size() < 30) && n < 300) begin
            cycle();
            n++;
        end
        chk("t6_reached_midblock", 32'(n < 300), 32'd1);
        chk_en = 0;
        reset = 1'b1;
        @(negedge clk);
        chk("t6_give_in_reset", 32'(give), 32'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("t6_ovalid", 32'(ovalid), 32'd0);
        chk("t6_nblk", nblk, 32'd0);
        chk("t6_oeop", 32'(oeop), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        oready = 1'b1;
        @(negedge clk);
        chk("t6_ptr_zero", 32'(give), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
